div_8bit_seq: RTL

- Sequential 8-bit unsigned restoring divider.
- Subtract-based counterpart to the team's 8-bit add datapath: it performs one trial subtraction per clock, using the same 8-bit operand width.
- Sits beside the adder in the arithmetic unit and uses a start/busy/done handshake.
- Produces quotient, remainder and a divide-by-zero flag.

---
 rtl/div_8bit_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/div_8bit_seq.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, start/busy/done
// handshake, quotient/remainder held until the next completion, divide-by-zero flagged.
module div_8bit_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;
   logic              dbz_q, dbz_d;

   logic [WIDTH-1:0]  r_shift;
   logic [WIDTH:0]    trial;
   logic [WIDTH-1:0]  r_next;
   logic [WIDTH-1:0]  q_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         q_q         <= '0;
         r_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         r_q         <= r_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   // One restoring step on the shifted {R,Q}; trial[WIDTH] is the borrow.
   always_comb begin
      r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
      trial   = {1'b0, r_shift} - {1'b0, d_q};
      r_next  = trial[WIDTH] ? r_shift : trial[WIDTH-1:0];
      q_next  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
   end

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      r_d         = r_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               q_d   = dividend;
               d_d   = divisor;
               r_d   = '0;
               cnt_d = CntW'(WIDTH);
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               quotient_d  = q_next;
               remainder_d = r_next;
               state_d     = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy        = (state_q == StCalc);
   assign done        = (state_q == StDone);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule
